// File: rtl/req_seq_pkg.sv
// Shared types and default parameters for the request sequencer
// (FSM state encoding and the completion record).
package req_seq_pkg;

  localparam int DEPTH_DEF   = 4;
  localparam int ID_W_DEF    = 4;
  localparam int LAT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int GAP_DEF     = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [LAT_W_DEF-1:0] latency;
    logic                 timeout;
  } done_t;

endpackage

// File: rtl/req_fifo.sv
// Command ID queue: synchronous FIFO, DEPTH x W, async active-low reset.
// A push while full is dropped; a pop while empty is ignored.
module req_fifo
  import req_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = ID_W_DEF
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer MSB distinguishes full from empty when addresses match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/request_sequencer.sv
// Queues command IDs and runs one request/grant handshake per command,
// reporting latency or timeout. Optional stats under REQ_SEQ_STATS_EN.
module request_sequencer
  import req_seq_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int LAT_W   = LAT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int GAP     = GAP_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ID_W-1:0]  cmd_id,
  output logic             request,
  input  logic             grant,
  output logic             done_valid,
  output logic [ID_W-1:0]  done_id,
  output logic [LAT_W-1:0] done_latency,
  output logic             done_timeout,
  output logic             busy,
  output logic             protocol_err,
  output logic [LAT_W-1:0] stat_max_latency,
  output logic [15:0]      stat_grants
);

  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LAT_W:0]   TIMEOUT_V = (LAT_W + 1)'(TIMEOUT);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_request;
  logic             w_req_nxt;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [LAT_W-1:0] w_lat_nxt;
  logic [LAT_W:0]   w_lat_inc;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [ID_W-1:0]  r_cur_id;
  logic [ID_W-1:0]  w_id_nxt;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [ID_W-1:0]  w_head;
  logic             w_done_fire;
  logic             w_done_to;
  logic [LAT_W-1:0] w_done_lat;
  logic             r_done_valid;
  logic [ID_W-1:0]  r_done_id;
  logic [LAT_W-1:0] r_done_lat;
  logic             r_done_to;
  logic             r_prot_err;

  // Command handshake: an ID is accepted on a clock edge where cmd_valid
  // and cmd_ready are both high; cmd_ready is simply !full of the queue.
  req_fifo #(.DEPTH(DEPTH), .W(ID_W)) u_fifo (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_push    (cmd_valid),
    .i_data    (cmd_id),
    .i_pop     (w_pop),
    .o_data    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_lat_inc = {1'b0, r_lat_cnt} + (LAT_W + 1)'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_request;
    w_lat_nxt   = r_lat_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_id_nxt    = r_cur_id;
    w_pop       = 1'b0;
    w_done_fire = 1'b0;
    w_done_to   = 1'b0;
    w_done_lat  = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_id_nxt    = w_head;
          w_req_nxt   = 1'b1;
          w_lat_nxt   = '0;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Grant takes priority over a timeout landing on the same edge.
        if (grant) begin
          w_req_nxt   = 1'b0;
          w_done_fire = 1'b1;
          w_done_lat  = w_lat_inc[LAT_W-1:0];
          w_state_nxt = ST_RELEASE;
        end else if (w_lat_inc == TIMEOUT_V) begin
          w_req_nxt   = 1'b0;
          w_done_fire = 1'b1;
          w_done_to   = 1'b1;
          w_done_lat  = LAT_W'(TIMEOUT);
          w_state_nxt = ST_RELEASE;
        end else if (!(&r_lat_cnt)) begin
          w_lat_nxt = w_lat_inc[LAT_W-1:0];
        end
      end
      ST_RELEASE: begin
        if (!grant) begin
          if (GAP > 0) begin
            w_gap_nxt   = '0;
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
        else                       w_gap_nxt   = r_gap_cnt + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_request    <= 1'b0;
      r_lat_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_cur_id     <= '0;
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_done_lat   <= '0;
      r_done_to    <= 1'b0;
      r_prot_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_request    <= w_req_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_cur_id     <= w_id_nxt;
      r_done_valid <= w_done_fire;
      if (w_done_fire) begin
        r_done_id  <= r_cur_id;
        r_done_lat <= w_done_lat;
        r_done_to  <= w_done_to;
      end
      if (grant && (r_state == ST_IDLE || r_state == ST_GAP)) r_prot_err <= 1'b1;
    end
  end

  assign cmd_ready    = !w_full;
  assign request      = r_request;
  assign done_valid   = r_done_valid;
  assign done_id      = r_done_id;
  assign done_latency = r_done_lat;
  assign done_timeout = r_done_to;
  assign busy         = (r_state != ST_IDLE) || !w_empty;
  assign protocol_err = r_prot_err;

`ifdef REQ_SEQ_STATS_EN
  logic [LAT_W-1:0] r_stat_max;
  logic [15:0]      r_stat_grants;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stat_max    <= '0;
      r_stat_grants <= '0;
    end else if (w_done_fire && !w_done_to) begin
      if (w_done_lat > r_stat_max) r_stat_max <= w_done_lat;
      if (r_stat_grants != 16'hFFFF) r_stat_grants <= r_stat_grants + 16'd1;
    end
  end

  assign stat_max_latency = r_stat_max;
  assign stat_grants      = r_stat_grants;
`else
  assign stat_max_latency = '0;
  assign stat_grants      = '0;
`endif

endmodule

// File: tb/tb_request_sequencer.sv
// Bench for request_sequencer: downstream is a tap-selectable delay line
// (tap 3 = the 3-stage stage, latency 4) or a directly forced grant.
`timescale 1ns/1ps
module tb_request_sequencer;
  import req_seq_pkg::*;

  localparam int ID_W  = ID_W_DEF;
  localparam int LAT_W = LAT_W_DEF;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ID_W-1:0]  cmd_id = '0;
  logic             request;
  logic             grant;
  logic             done_valid;
  logic [ID_W-1:0]  done_id;
  logic [LAT_W-1:0] done_latency;
  logic             done_timeout;
  logic             busy;
  logic             protocol_err;
  logic [LAT_W-1:0] stat_max_latency;
  logic [15:0]      stat_grants;

  logic [15:0] sr;
  int          tap = 3;
  logic        force_en = 1'b0;
  logic        force_val = 1'b0;

  assign grant = force_en ? force_val : sr[tap-1];

  always @(posedge clock or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= {sr[14:0], request};
  end

  request_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_id           (cmd_id),
    .request          (request),
    .grant            (grant),
    .done_valid       (done_valid),
    .done_id          (done_id),
    .done_latency     (done_latency),
    .done_timeout     (done_timeout),
    .busy             (busy),
    .protocol_err     (protocol_err),
    .stat_max_latency (stat_max_latency),
    .stat_grants      (stat_grants)
  );

  // scoreboard
  done_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clock) begin
    if (reset && done_valid) begin
      done_t got;
      done_t exp;
      got = {done_id, done_latency, done_timeout};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got id=%0d lat=%0d to=%0b, required no completion",
                 done_id, done_latency, done_timeout);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL done_record: got id=%0d lat=%0d to=%0b, required id=%0d lat=%0d to=%0b",
                   got.id, got.latency, got.timeout, exp.id, exp.latency, exp.timeout);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic push(input logic [ID_W-1:0] id, input int lat, input logic to,
                      input bit track, output bit accepted);
    cmd_valid = 1'b1;
    cmd_id    = id;
    accepted  = cmd_ready;
    if (accepted && track) exp_q.push_back({id, LAT_W'(lat), to});
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_request(input logic val, input int budget, output int cyc);
    cyc = 0;
    while (request !== val && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    checks++;
    if ({request, done_valid, done_timeout, busy, protocol_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got req=%b dv=%b to=%b busy=%b perr=%b, required all 0",
               request, done_valid, done_timeout, busy, protocol_err);
    end
    checks++;
    if ({done_id, done_latency, stat_max_latency, stat_grants} !== '0) begin
      errors++;
      $display("FAIL reset_values: got id=%0d lat=%0d smax=%0d sg=%0d, required 0",
               done_id, done_latency, stat_max_latency, stat_grants);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    bit acc;
    int cyc;
    @(negedge clock);
    push(4'd5, 4, 1'b0, 1'b1, acc);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b, required 1", acc); end
    checks++;
    if (request !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b, required 0", request); end
    @(negedge clock);
    checks++;
    if (request !== 1'b1) begin errors++; $display("FAIL single_req_rise: got %b, required 1", request); end
    wait_request(1'b0, 40, cyc);
    checks++;
    if (request !== 1'b0 || cyc != 4) begin
      errors++; $display("FAIL single_req_high_cycles: got %0d, required 4", cyc);
    end
    cyc = 0;
    while (grant !== 1'b0 && cyc < 20) begin @(negedge clock); cyc++; end
    checks++;
    if (grant !== 1'b0 || cyc != 3) begin
      errors++; $display("FAIL single_grant_fall: got %0d cycles, required 3", cyc);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy: got %b, required 1", busy); end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL single_idle: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int cyc;
    @(negedge clock);
    push(4'd9, 4, 1'b0, 1'b1, acc);
    wait_request(1'b1, 10, cyc);
    checks++;
    if (request !== 1'b1) begin errors++; $display("FAIL b2b_first_req: got %b, required 1", request); end
    for (int i = 1; i <= 5; i++) begin
      push(ID_W'(i), 4, 1'b0, 1'b1, acc);
      checks++;
      if (acc !== (i < 5)) begin
        errors++; $display("FAIL b2b_ready_%0d: got %b, required %b", i, acc, (i < 5));
      end
    end
    wait_idle(300, cyc);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit acc;
    int cyc;
    force_en = 1'b1;
    force_val = 1'b0;
    @(negedge clock);
    push(4'd7, 16, 1'b1, 1'b1, acc);
    wait_request(1'b1, 10, cyc);
    wait_request(1'b0, 40, cyc);
    checks++;
    if (request !== 1'b0 || cyc != 16) begin
      errors++; $display("FAIL timeout_req_cycles: got %0d, required 16", cyc);
    end
    wait_idle(20, cyc);
    force_en = 1'b0;
    push(4'd8, 4, 1'b0, 1'b1, acc);
    wait_idle(60, cyc);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_next_cmd: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_grant_on_timeout();
    bit acc;
    int cyc;
    force_en = 1'b1;
    force_val = 1'b0;
    @(negedge clock);
    push(4'd6, 16, 1'b0, 1'b1, acc);
    wait_request(1'b1, 10, cyc);
    repeat (15) @(negedge clock);
    force_val = 1'b1;
    @(negedge clock);
    checks++;
    if (request !== 1'b0) begin errors++; $display("FAIL edge_grant_req_drop: got %b, required 0", request); end
    force_val = 1'b0;
    wait_idle(20, cyc);
    force_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL edge_grant_done: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int cyc;
    @(negedge clock);
    push(4'd3, 4, 1'b0, 1'b0, acc);
    push(4'd4, 4, 1'b0, 1'b0, acc);
    wait_request(1'b1, 10, cyc);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (request !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_state: got req=%b busy=%b ready=%b, required 0 0 1", request, busy, cmd_ready);
    end
    checks++;
    if (stat_max_latency !== '0 || stat_grants !== '0) begin
      errors++; $display("FAIL midreset_stats: got %0d %0d, required 0 0", stat_max_latency, stat_grants);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || request !== 1'b0) begin
      errors++; $display("FAIL midreset_queue_empty: got busy=%b req=%b, required 0 0", busy, request);
    end
    push(4'd10, 4, 1'b0, 1'b1, acc);
    wait_idle(60, cyc);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL midreset_next_cmd: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_stats();
    bit acc;
    int cyc;
    tap = 5;
    @(negedge clock);
    push(4'd11, 6, 1'b0, 1'b1, acc);
    wait_idle(60, cyc);
    tap = 3;
`ifdef REQ_SEQ_STATS_EN
    checks++;
    if (stat_max_latency !== 8'd6 || stat_grants !== 16'd2) begin
      errors++; $display("FAIL stats_values: got max=%0d grants=%0d, required 6 2", stat_max_latency, stat_grants);
    end
`else
    checks++;
    if (stat_max_latency !== '0 || stat_grants !== '0) begin
      errors++; $display("FAIL stats_tied: got max=%0d grants=%0d, required 0 0", stat_max_latency, stat_grants);
    end
`endif
  endtask

  task automatic test_protocol_err();
    @(negedge clock);
    checks++;
    if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b, required 0", protocol_err); end
    force_en  = 1'b1;
    force_val = 1'b1;
    @(negedge clock);
    force_val = 1'b0;
    @(negedge clock);
    checks++;
    if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b, required 1", protocol_err); end
    repeat (3) @(negedge clock);
    checks++;
    if (protocol_err !== 1'b1 || busy !== 1'b0 || request !== 1'b0) begin
      errors++; $display("FAIL perr_sticky: got perr=%b busy=%b req=%b, required 1 0 0", protocol_err, busy, request);
    end
    force_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_grant_on_timeout();
    test_reset_mid();
    test_stats();
    test_protocol_err();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_pending: got %0d, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_sequencer.md
Name: request_sequencer

Overview:
- Upstream requester for the 3-stage request→grant delay-line stage.
- Queues command IDs and issues one request per command on a single-bit `request` line.
- Waits for `grant`, then drops `request` and waits for `grant` to return low.
- Reports per-command grant latency or timeout; all timing is relative to the `clock` posedge.

Parameters:
- DEPTH, 4: command queue entries (power of 2, ≥2).
- ID_W, 4: command ID width.
- LAT_W, 8: latency counter width.
- TIMEOUT, 16: cycles to wait for grant before aborting (1 ≤ TIMEOUT < 2**LAT_W).
- GAP, 1: idle cycles enforced after grant returns low, before the next request (0 allowed).

Ports:
- clock  in  1  sole clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  queue can accept; equals !full.
- cmd_id  in  ID_W  command ID, captured when cmd_valid && cmd_ready.
- request  out  1  registered request to downstream delay stage.
- grant  in  1  grant from downstream.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  ID_W  ID of completed command.
- done_latency  out  LAT_W  cycles from request rise to grant sampled high.
- done_timeout  out  1  1 = aborted without grant.
- busy  out  1  state != IDLE or queue non-empty.
- protocol_err  out  1  sticky; grant sampled 1 while not in REQ or RELEASE.
- stat_max_latency  out  LAT_W  see Optional Feature.
- stat_grants  out  16  see Optional Feature.

Behaviour:
- Reset (async, reset==0): all outputs 0, except cmd_ready=1. Queue emptied, FSM=IDLE. `request` drops immediately, mid-operation included; no done pulse is emitted for the aborted command.
- FSM states: IDLE, REQ, RELEASE, GAP.
- IDLE, queue non-empty: pop head, latch ID, request<=1, lat_cnt<=0, go to REQ. Earliest request rise is the cycle after the push edge; there is no bypass.
- REQ: lat_cnt increments each edge.
  - grant sampled 1: request<=0, done_valid pulse, done_latency=lat_cnt+1, done_timeout=0, go to RELEASE.
  - lat_cnt+1==TIMEOUT with grant sampled 0: same, but done_timeout=1 and done_latency=TIMEOUT.
  - Grant and timeout on the same edge: grant wins.
- RELEASE: hold until grant sampled 0. Then go to GAP if GAP>0, else IDLE. No timeout in this state.
- GAP: count GAP edges, then go to IDLE.
- Latency definition: request rises at edge E0; grant first sampled high at E0+k; done_latency=k. Against the 3-stage delay line, k=4.
- Queue full: cmd_ready=0. A push is refused even if a pop occurs on the same edge.
- Protocol error: grant==1 sampled in IDLE or GAP sets protocol_err. It clears only on reset; FSM behaviour is unaffected.
- Counter widths: lat_cnt saturates at 2**LAT_W-1 (unreachable given the TIMEOUT constraint). The GAP counter is sized $clog2(GAP+1).

Optional Feature:
- Macro: REQ_SEQ_STATS_EN.
- Defined:
  - stat_max_latency holds the max done_latency over non-timeout completions.
  - stat_grants counts non-timeout completions, saturating at 16'hFFFF.
  - Both reset to 0.
- Undefined: both ports are tied to 0 and no stats logic is synthesised. The port list is identical either way.

Decomposition:
- Package req_seq_pkg:
  - state_e enum (IDLE, REQ, RELEASE, GAP).
  - done_t struct {id, latency, timeout}.
  - Default parameter constants.
- Sub-module req_fifo:
  - Synchronous FIFO with DEPTH×ID_W storage, push/pop/full/empty.
  - Asynchronous active-low reset.
- The FSM, counters and stats live in request_sequencer.

Test Plan:
- Single command, id=5, with the 3-stage delay line as downstream → request high 1 cycle after push; done_valid pulse with id=5, latency=4, timeout=0; grant falls 3 cycles after request falls; then GAP=1 idle cycle.
- Push ids 1,2,3,4,5 back-to-back while the first is in flight → cmd_ready=0 on the 5th push attempt; completions in order 1..4 with latency=4 each.
- grant tied 0, TIMEOUT=16 → done_timeout=1, done_latency=16, request low after 16 cycles; the next command then issues normally.
- grant forced to 1 on exactly the TIMEOUT edge → timeout=0, latency=16.
- reset pulled low while in REQ → request=0 immediately, queue empty, no done pulse; after release, a new command completes with latency=4.
- grant pulsed 1 while in IDLE → protocol_err=1 and stays set. With REQ_SEQ_STATS_EN defined, after latencies 4 and 6: stat_max_latency=6, stat_grants=2.
